// File: rtl/nand_buf_pkg.sv
// rtl/nand_buf_pkg.sv - shared types and defaults for the NAND page ping-pong buffer
// Purpose: bank state and side enums plus default geometry constants.
// Ports: none (package).
package nand_buf_pkg;

  typedef enum logic [2:0] {
    FREE      = 3'd0,
    FILL_H    = 3'd1,
    FILL_C    = 3'd2,
    FULL_TO_C = 3'd3,
    FULL_TO_H = 3'd4,
    DRAIN     = 3'd5
  } bank_state_e;

  typedef enum logic {
    SIDE_HOST  = 1'b0,
    SIDE_CNTRL = 1'b1
  } side_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PAGE_DEPTH = 2048;
  localparam int DEF_NUM_BANKS  = 2;

endpackage

// File: rtl/nand_page_ram.sv
// rtl/nand_page_ram.sv - banked page store, one write and one registered read port per side
// Purpose: NUM_BANKS*PAGE_DEPTH word array addressed as {bank, word}.
// Ports: clk, rst_n (async, clears read registers only);
//        wa_* / wb_* : host-side / controller-side write ports;
//        ra_* / rb_* : host-side / controller-side registered read ports.
// The two sides never touch the same bank in one cycle, so the write ports never collide.
module nand_page_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [WIDTH-1:0]  wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              ra_en,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [WIDTH-1:0]  ra_data,
  input  logic              rb_en,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  rb_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    if (wb_en) mem[wb_addr] <= wb_data;
  end

  always_comb begin
    ra_data_d = ra_en ? mem[ra_addr] : ra_data_q;
    rb_data_d = rb_en ? mem[rb_addr] : rb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data_q <= '0;
      rb_data_q <= '0;
    end else begin
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign ra_data = ra_data_q;
  assign rb_data = rb_data_q;

endmodule

// File: rtl/nand_page_pingpong_buffer.sv
// rtl/nand_page_pingpong_buffer.sv - multi-bank page buffer between host and flash controller
// Purpose: each bank holds one page; a side fills a free bank, which is then queued
//          in order for the opposite side to drain.
// Ports: clk, rst_n (async active-low);
//        <side>_we/_wdata/_wready/_abort : page fill;
//        <side>_re/_rdata/_rvalid        : page drain, data one cycle after re;
//        <side>_page_avail/_page_done    : queued page present / last word read;
//        overflow_err, underflow_err     : sticky until reset.
// Option: NAND_BUF_PARITY_EN adds a stored even-parity bit per word and the
//         host_parity_err / cntrl_parity_err outputs.
module nand_page_pingpong_buffer
  import nand_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PAGE_DEPTH = DEF_PAGE_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int AW         = $clog2(PAGE_DEPTH),
  parameter int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_we,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_wready,
  input  logic                  host_abort,
  input  logic                  host_re,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  host_page_avail,
  output logic                  host_page_done,
  input  logic                  cntrl_we,
  input  logic [DATA_WIDTH-1:0] cntrl_wdata,
  output logic                  cntrl_wready,
  input  logic                  cntrl_abort,
  input  logic                  cntrl_re,
  output logic [DATA_WIDTH-1:0] cntrl_rdata,
  output logic                  cntrl_rvalid,
  output logic                  cntrl_page_avail,
  output logic                  cntrl_page_done,
`ifdef NAND_BUF_PARITY_EN
  output logic                  host_parity_err,
  output logic                  cntrl_parity_err,
`endif
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int CW = BW + 1;
`ifdef NAND_BUF_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  // Index 0 is the host side, index 1 the controller side.
  logic [1:0] we, abort, re, wready;
  logic [DATA_WIDTH-1:0] wdata [2];

  bank_state_e   bank_state_q [NUM_BANKS], bank_state_d [NUM_BANKS];
  logic [1:0]    fill_active_q, fill_active_d;
  logic [BW-1:0] fill_bank_q [2], fill_bank_d [2];
  logic [AW-1:0] fill_cnt_q [2], fill_cnt_d [2];
  logic [AW-1:0] drain_cnt_q [2], drain_cnt_d [2];
  // Per-destination in-order queue of full banks; entry 0 is the head.
  logic [BW-1:0] q_q [2][NUM_BANKS], q_d [2][NUM_BANKS];
  logic [CW-1:0] qcnt_q [2], qcnt_d [2];
  logic [1:0]    avail_q, avail_d, rvalid_q, rvalid_d, done_q, done_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  logic [BW-1:0]    first_free, second_free, bank_sel;
  logic [BW-1:0]    alloc_bank [2];
  logic [CW-1:0]    free_cnt;
  logic             host_alloc;
  logic [1:0]       ram_we, ram_re;
  logic [BW+AW-1:0] ram_waddr [2], ram_raddr [2];
  logic [MW-1:0]    ram_wdata [2], ram_rdata [2];

  assign we[SIDE_HOST]     = host_we;
  assign we[SIDE_CNTRL]    = cntrl_we;
  assign abort[SIDE_HOST]  = host_abort;
  assign abort[SIDE_CNTRL] = cntrl_abort;
  assign re[SIDE_HOST]     = host_re;
  assign re[SIDE_CNTRL]    = cntrl_re;
  assign wdata[0]          = host_wdata;
  assign wdata[1]          = cntrl_wdata;

  // Lowest and second-lowest FREE banks; the second one serves the controller
  // when the host claims the first in the same cycle.
  always_comb begin
    first_free  = '0;
    second_free = '0;
    free_cnt    = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_state_q[b] == FREE) begin
        second_free = first_free;
        first_free  = BW'(b);
        free_cnt    = free_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    host_alloc    = !fill_active_q[0] && we[0] && !abort[0] && (free_cnt != '0);
    wready[0]     = fill_active_q[0] || (free_cnt != '0);
    wready[1]     = fill_active_q[1] ||
                    (host_alloc ? (free_cnt >= CW'(2)) : (free_cnt != '0));
    alloc_bank[0] = first_free;
    alloc_bank[1] = host_alloc ? second_free : first_free;
  end

  always_comb begin
    bank_state_d  = bank_state_q;
    fill_active_d = fill_active_q;
    fill_bank_d   = fill_bank_q;
    fill_cnt_d    = fill_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    q_d           = q_q;
    qcnt_d        = qcnt_q;
    rvalid_d      = '0;
    done_d        = '0;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    ram_we        = '0;
    ram_re        = '0;
    ram_waddr[0]  = '0;
    ram_waddr[1]  = '0;
    ram_raddr[0]  = '0;
    ram_raddr[1]  = '0;
    bank_sel      = '0;

    // Drains first so a pop frees a queue slot before a push on the same side.
    for (int s = 0; s < 2; s++) begin
      if (re[s] && !avail_q[s]) unf_d = 1'b1;
      if (re[s] && avail_q[s]) begin
        rvalid_d[s]  = 1'b1;
        ram_re[s]    = 1'b1;
        ram_raddr[s] = {q_q[s][0], drain_cnt_q[s]};
        if (drain_cnt_q[s] == AW'(PAGE_DEPTH - 1)) begin
          bank_state_d[q_q[s][0]] = FREE;
          drain_cnt_d[s]          = '0;
          done_d[s]               = 1'b1;
          for (int i = 0; i < NUM_BANKS - 1; i++) q_d[s][i] = q_q[s][i+1];
          qcnt_d[s] = qcnt_q[s] - 1'b1;
        end else begin
          bank_state_d[q_q[s][0]] = DRAIN;
          drain_cnt_d[s]          = drain_cnt_q[s] + 1'b1;
        end
      end
    end

    for (int s = 0; s < 2; s++) begin
      if (we[s] && !wready[s]) ovf_d = 1'b1;
      if (abort[s]) begin
        if (fill_active_q[s]) bank_state_d[fill_bank_q[s]] = FREE;
        fill_active_d[s] = 1'b0;
        fill_cnt_d[s]    = '0;
      end else if (we[s] && wready[s]) begin
        bank_sel     = fill_active_q[s] ? fill_bank_q[s] : alloc_bank[s];
        ram_we[s]    = 1'b1;
        ram_waddr[s] = {bank_sel, fill_cnt_q[s]};
        if (fill_cnt_q[s] == AW'(PAGE_DEPTH - 1)) begin
          bank_state_d[bank_sel] = (s == 0) ? FULL_TO_C : FULL_TO_H;
          q_d[1-s][qcnt_d[1-s][BW-1:0]] = bank_sel;
          qcnt_d[1-s]      = qcnt_d[1-s] + 1'b1;
          fill_active_d[s] = 1'b0;
          fill_cnt_d[s]    = '0;
        end else begin
          bank_state_d[bank_sel] = (s == 0) ? FILL_H : FILL_C;
          fill_active_d[s]       = 1'b1;
          fill_bank_d[s]         = bank_sel;
          fill_cnt_d[s]          = fill_cnt_q[s] + 1'b1;
        end
      end
    end

    avail_d[0] = (qcnt_d[0] != '0);
    avail_d[1] = (qcnt_d[1] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_state_q[b] <= FREE;
      for (int s = 0; s < 2; s++) begin
        fill_bank_q[s] <= '0;
        fill_cnt_q[s]  <= '0;
        drain_cnt_q[s] <= '0;
        qcnt_q[s]      <= '0;
        for (int i = 0; i < NUM_BANKS; i++) q_q[s][i] <= '0;
      end
      fill_active_q <= '0;
      avail_q       <= '0;
      rvalid_q      <= '0;
      done_q        <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      bank_state_q  <= bank_state_d;
      fill_active_q <= fill_active_d;
      fill_bank_q   <= fill_bank_d;
      fill_cnt_q    <= fill_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      q_q           <= q_d;
      qcnt_q        <= qcnt_d;
      avail_q       <= avail_d;
      rvalid_q      <= rvalid_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

`ifdef NAND_BUF_PARITY_EN
  // Stored bit makes the XOR over the whole stored word zero.
  assign ram_wdata[0] = {^wdata[0], wdata[0]};
  assign ram_wdata[1] = {^wdata[1], wdata[1]};
  assign host_parity_err  = rvalid_q[0] & (^ram_rdata[0]);
  assign cntrl_parity_err = rvalid_q[1] & (^ram_rdata[1]);
`else
  assign ram_wdata[0] = wdata[0];
  assign ram_wdata[1] = wdata[1];
`endif

  nand_page_ram #(
    .WIDTH (MW),
    .DEPTH (NUM_BANKS * PAGE_DEPTH),
    .ADDR_W(BW + AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wa_en  (ram_we[0]),
    .wa_addr(ram_waddr[0]),
    .wa_data(ram_wdata[0]),
    .wb_en  (ram_we[1]),
    .wb_addr(ram_waddr[1]),
    .wb_data(ram_wdata[1]),
    .ra_en  (ram_re[0]),
    .ra_addr(ram_raddr[0]),
    .ra_data(ram_rdata[0]),
    .rb_en  (ram_re[1]),
    .rb_addr(ram_raddr[1]),
    .rb_data(ram_rdata[1])
  );

  assign host_wready      = wready[0];
  assign cntrl_wready     = wready[1];
  assign host_rdata       = ram_rdata[0][DATA_WIDTH-1:0];
  assign cntrl_rdata      = ram_rdata[1][DATA_WIDTH-1:0];
  assign host_rvalid      = rvalid_q[0];
  assign cntrl_rvalid     = rvalid_q[1];
  assign host_page_avail  = avail_q[0];
  assign cntrl_page_avail = avail_q[1];
  assign host_page_done   = done_q[0];
  assign cntrl_page_done  = done_q[1];
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: tb/tb_nand_page_pingpong_buffer.sv
// tb/tb_nand_page_pingpong_buffer.sv - self-checking bench for nand_page_pingpong_buffer
module tb_nand_page_pingpong_buffer;

  localparam int DW = 16;
  localparam int PD = 8;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_we = 1'b0, host_abort = 1'b0, host_re = 1'b0;
  logic [DW-1:0] host_wdata = '0;
  logic          cntrl_we = 1'b0, cntrl_abort = 1'b0, cntrl_re = 1'b0;
  logic [DW-1:0] cntrl_wdata = '0;
  logic          host_wready, host_rvalid, host_page_avail, host_page_done;
  logic          cntrl_wready, cntrl_rvalid, cntrl_page_avail, cntrl_page_done;
  logic [DW-1:0] host_rdata, cntrl_rdata;
  logic          overflow_err, underflow_err;
`ifdef NAND_BUF_PARITY_EN
  logic          host_parity_err, cntrl_parity_err;
`endif

  always #5 clk = ~clk;

  nand_page_pingpong_buffer #(
    .DATA_WIDTH(DW),
    .PAGE_DEPTH(PD),
    .NUM_BANKS (NB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host_we         (host_we),
    .host_wdata      (host_wdata),
    .host_wready     (host_wready),
    .host_abort      (host_abort),
    .host_re         (host_re),
    .host_rdata      (host_rdata),
    .host_rvalid     (host_rvalid),
    .host_page_avail (host_page_avail),
    .host_page_done  (host_page_done),
    .cntrl_we        (cntrl_we),
    .cntrl_wdata     (cntrl_wdata),
    .cntrl_wready    (cntrl_wready),
    .cntrl_abort     (cntrl_abort),
    .cntrl_re        (cntrl_re),
    .cntrl_rdata     (cntrl_rdata),
    .cntrl_rvalid    (cntrl_rvalid),
    .cntrl_page_avail(cntrl_page_avail),
    .cntrl_page_done (cntrl_page_done),
`ifdef NAND_BUF_PARITY_EN
    .host_parity_err (host_parity_err),
    .cntrl_parity_err(cntrl_parity_err),
`endif
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: words pending per fill side, words queued per destination,
  // whole pages queued per destination, words already drained of the head page.
  bit            fa [2];
  logic [DW-1:0] fbuf [2][$];
  logic [DW-1:0] wq [2][$];
  int            pages [2];
  int            dcnt [2];
  bit            m_ovf, m_unf;
  int            flip_cnt [2];

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      fa[s] = 1'b0;
      fbuf[s].delete();
      wq[s].delete();
      pages[s] = 0;
      dcnt[s] = 0;
      flip_cnt[s] = -1;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  // One clock cycle: drive inputs, check wready, advance model, check registered outputs.
  task automatic step(input bit w0, input logic [DW-1:0] d0, input bit a0, input bit r0,
                      input bit w1, input logic [DW-1:0] d1, input bit a1, input bit r1);
    bit w [2], a [2], r [2], wr [2], e_rv [2], e_done [2], e_pe [2];
    logic [DW-1:0] d [2], e_rd [2];
    int free;
    bit halloc;
    w[0] = w0; d[0] = d0; a[0] = a0; r[0] = r0;
    w[1] = w1; d[1] = d1; a[1] = a1; r[1] = r1;
    host_we = w0;  host_wdata = d0;  host_abort = a0;  host_re = r0;
    cntrl_we = w1; cntrl_wdata = d1; cntrl_abort = a1; cntrl_re = r1;
    #1;
    free   = NB - int'(fa[0]) - int'(fa[1]) - pages[0] - pages[1];
    halloc = !fa[0] && w[0] && !a[0] && (free > 0);
    wr[0]  = fa[0] || (free > 0);
    wr[1]  = fa[1] || (halloc ? (free >= 2) : (free > 0));
    check("host_wready", host_wready, wr[0]);
    check("cntrl_wready", cntrl_wready, wr[1]);
    for (int s = 0; s < 2; s++) begin
      e_rv[s] = 1'b0; e_done[s] = 1'b0; e_pe[s] = 1'b0; e_rd[s] = '0;
      if (r[s] && pages[s] == 0) m_unf = 1'b1;
      if (r[s] && pages[s] > 0) begin
        e_rv[s] = 1'b1;
        e_rd[s] = wq[s].pop_front();
        if (flip_cnt[s] == 0) e_pe[s] = 1'b1;
        if (flip_cnt[s] >= 0) flip_cnt[s]--;
        dcnt[s]++;
        if (dcnt[s] == PD) begin
          dcnt[s] = 0;
          pages[s]--;
          e_done[s] = 1'b1;
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (w[s] && !wr[s]) m_ovf = 1'b1;
      if (a[s]) begin
        fa[s] = 1'b0;
        fbuf[s].delete();
      end else if (w[s] && wr[s]) begin
        fbuf[s].push_back(d[s]);
        fa[s] = 1'b1;
        if (fbuf[s].size() == PD) begin
          for (int i = 0; i < PD; i++) wq[1-s].push_back(fbuf[s][i]);
          pages[1-s]++;
          fa[s] = 1'b0;
          fbuf[s].delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check("host_rvalid", host_rvalid, e_rv[0]);
    check("cntrl_rvalid", cntrl_rvalid, e_rv[1]);
    if (e_rv[0]) check("host_rdata", host_rdata, e_rd[0]);
    if (e_rv[1]) check("cntrl_rdata", cntrl_rdata, e_rd[1]);
    check("host_page_done", host_page_done, e_done[0]);
    check("cntrl_page_done", cntrl_page_done, e_done[1]);
    check("host_page_avail", host_page_avail, pages[0] > 0);
    check("cntrl_page_avail", cntrl_page_avail, pages[1] > 0);
    check("overflow_err", overflow_err, m_ovf);
    check("underflow_err", underflow_err, m_unf);
`ifdef NAND_BUF_PARITY_EN
    check("host_parity_err", host_parity_err, e_pe[0]);
    check("cntrl_parity_err", cntrl_parity_err, e_pe[1]);
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_host_rvalid", host_rvalid, 1'b0);
    check("rst_cntrl_rvalid", cntrl_rvalid, 1'b0);
    check("rst_host_rdata", host_rdata, '0);
    check("rst_cntrl_rdata", cntrl_rdata, '0);
    check("rst_host_avail", host_page_avail, 1'b0);
    check("rst_cntrl_avail", cntrl_page_avail, 1'b0);
    check("rst_host_done", host_page_done, 1'b0);
    check("rst_cntrl_done", cntrl_page_done, 1'b0);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_underflow", underflow_err, 1'b0);
    check("rst_host_wready", host_wready, 1'b1);
    check("rst_cntrl_wready", cntrl_wready, 1'b1);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Host page to controller, then drained in order.
    for (int i = 0; i < PD; i++) step(1, 16'h1000 + 16'(i), 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < PD; i++) step(0, '0, 0, 0, 0, '0, 0, 1);
    idle();

    // Two full pages plus one refused beat, then both drained.
    for (int i = 0; i < 2 * PD + 1; i++) step(1, 16'h3000 + 16'(i), 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 2 * PD; i++) step(0, '0, 0, 0, 0, '0, 0, 1);
    idle();

    // Controller fills B while host drains A.
    for (int i = 0; i < PD; i++) step(0, '0, 0, 0, 1, 16'hA000 + 16'(i), 0, 0);
    for (int i = 0; i < PD; i++) step(0, '0, 0, 1, 1, 16'hB000 + 16'(i), 0, 0);
    for (int i = 0; i < PD + 1; i++) step(0, '0, 0, 1, 0, '0, 0, 0);

    // Partial fill discarded by abort.
    for (int i = 0; i < 3; i++) step(1, 16'h0F00 + 16'(i), 0, 0, 0, '0, 0, 0);
    step(0, '0, 1, 0, 0, '0, 0, 0);
    for (int i = 0; i < PD; i++) step(1, 16'h2000 + 16'(i), 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < PD; i++) step(0, '0, 0, 0, 0, '0, 0, 1);

    // One FREE bank left, both sides start a fill together: host wins.
    for (int i = 0; i < PD; i++) step(1, 16'h4000 + 16'(i), 0, 0, 0, '0, 0, 0);
    step(1, 16'h4100, 0, 0, 1, 16'h4200, 0, 0);
    for (int i = 1; i < PD; i++) step(1, 16'h4100 + 16'(i), 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 2 * PD; i++) step(0, '0, 0, 0, 0, '0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 50);
    end

    // Reset while the controller is halfway through a page.
    for (int n = 0; n < 4 * PD; n++) step(0, '0, 0, 0, 0, '0, 0, 1);
    for (int n = 0; n < 4 * PD; n++) step(0, '0, 0, 1, 0, '0, 0, 0);
    for (int i = 0; i < PD; i++) step(1, 16'h6000 + 16'(i), 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 0, '0, 0, 1);
    host_we = 1'b0; host_abort = 1'b0; host_re = 1'b0;
    cntrl_we = 1'b0; cntrl_abort = 1'b0; cntrl_re = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, '0, 0, 1, 0, '0, 0, 0);

`ifdef NAND_BUF_PARITY_EN
    // Flip the stored parity bit of word 2 in bank 0 and drain it.
    for (int i = 0; i < PD; i++) step(1, 16'h5000 + 16'(i), 0, 0, 0, '0, 0, 0);
    dut.u_ram.mem[2][DW] = ~dut.u_ram.mem[2][DW];
    flip_cnt[1] = 2;
    for (int i = 0; i < PD; i++) step(0, '0, 0, 0, 0, '0, 0, 1);
`endif

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
